debug_snapshot: RTL and testbench
=================================

Name: debug_snapshot

Overview:
Off-tag-clock debug serializer clocked by debug_clk. It replaces address-stepped single-bit peeking with a framed serial stream. On request it snapshots a vector of tag status flags (packet_complete, cmd_complete, handlematch, docrc, rx_en, tx_en, ...) and shifts it out as one self-delimiting frame on debug_out. It sits beside the top-level debug mux and consumes the same internal flags.

Parameters:
PROBE_W, 16, number of probe bits captured per frame; probe_in[0] is transmitted first.
SYNC_PAT, 4'b1010, frame sync header, transmitted MSB first.
SEQ_W, 4, width of the frame sequence counter; wraps modulo 2^SEQ_W.

Ports:
debug_clk  input  1  serial debug clock; all flops use its rising edge.
reset  input  1  asynchronous, active-high master reset.
probe_in  input  PROBE_W  status flags from the tag clk domain; asynchronous to debug_clk.
debug_arm  input  1  capture request, level-sensitive, asynchronous.
debug_out  output  1  serial frame data.
frame_active  output  1  high during every cycle in which debug_out carries a frame bit.
frame_done  output  1  one-cycle pulse in the GAP state.
seq_out  output  SEQ_W  sequence number of the next frame to be sent.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is debug_clk.
- Reset values: all outputs 0; state=IDLE; seq=0; sync flops, shadow register and shift register all 0.
- Reset mid-frame aborts the frame immediately. seq is not advanced for an aborted frame.
- Synchronizers: two-flop synchronizer on debug_arm and on each probe bit.
  - Probe bits are treated as quasi-static flags. No multi-bit coherency is guaranteed.
- Frame length: FRAME_LEN = 4 + SEQ_W + PROBE_W + 1 (25 with defaults).
- Frame content, in transmit order:
  - SYNC_PAT, MSB first.
  - seq, LSB first.
  - probe shadow, bit 0 first.
  - even-parity bit = XOR of all seq and probe bits.
- States:
  - IDLE: if arm_s2 is high, go to CAPTURE. Otherwise stay.
  - CAPTURE (1 cycle): on exit, load shift register sr[FRAME_LEN-1:0] with the frame in transmit order, sr[0] = SYNC_PAT[3]. Clear bitcnt. Go to SHIFT.
  - SHIFT: debug_out = sr[0]; frame_active=1. Each edge shifts sr right with 0 fill and increments bitcnt. Leave after the cycle with bitcnt == FRAME_LEN-1, going to GAP.
  - GAP (1 cycle): debug_out=0, frame_done=1, seq <= seq+1 (wraps). Then go to CAPTURE if arm_s2 is high (back-to-back frames), else IDLE.
- debug_out is driven directly from sr[0], which is 0 outside SHIFT. The output is glitch-free.
- Deasserting debug_arm mid-frame does not truncate the frame. It only prevents the next one.
- Latency:
  - debug_arm rising to the first frame bit is 4 debug_clk edges: 2 sync, 1 to CAPTURE, 1 load.
  - Captured probe value = probe_in as seen 2 edges before the CAPTURE exit edge.
- Frame period under continuous arm: 1 + FRAME_LEN + 1 = 27 cycles.
- bitcnt width = clog2(FRAME_LEN); it never exceeds FRAME_LEN-1.

Decomposition:
- Package debug_pkg holds:
  - state encoding (IDLE, CAPTURE, SHIFT, GAP);
  - SYNC_PAT default;
  - field widths;
  - FRAME_LEN function;
  - probe bit index constants (PRB_PACKET_COMPLETE=0, PRB_CMD_COMPLETE=1, PRB_HANDLEMATCH=2, PRB_DOCRC=3, PRB_RX_EN=4, PRB_TX_EN=5, ...), matching the existing debug address map.
- Sub-module sync2: parameterized-width two-flop synchronizer with async reset. Instantiated once for the probe bits and once for debug_arm.

Test Plan:
- Reset check: assert reset for 3 cycles -> debug_out=0, frame_active=0, frame_done=0, seq_out=0.
- Single frame: probe_in=16'h00A5 held, pulse debug_arm high for 3 cycles -> after 4 edges, 25 bits 1,0,1,0 | 0,0,0,0 | 1,0,1,0,0,1,0,1,0,0,0,0,0,0,0,0 | 0. Then frame_done pulses once and seq_out=1.
- Back-to-back with wrap: hold debug_arm high for 17 frames -> frames spaced 27 cycles apart with no idle gap. The seq field runs 0..15 then 0, and each parity bit is correct.
- Arm dropped mid-frame: deassert debug_arm at bit 10 -> the frame completes all 25 bits, then returns to IDLE. No second frame starts.
- Probe change during frame: probe_in changes 16'hFFFF -> 16'h0000 during SHIFT -> the transmitted data is 16'hFFFF with parity 0 (seq=0). The next frame carries 16'h0000.
- Reset mid-frame: assert reset at bit 7 -> debug_out=0 immediately. After release with arm high, the next frame carries seq=0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants for the debug snapshot serializer.
// Covers the FSM encoding, frame geometry and the probe bit map.
package debug_pkg;

  localparam int SYNC_W      = 4;
  localparam int PROBE_W_DEF = 16;
  localparam int SEQ_W_DEF   = 4;

  localparam logic [SYNC_W-1:0] SYNC_PAT_DEF = 4'b1010;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  // Probe positions match the legacy debug address map.
  localparam int PRB_PACKET_COMPLETE = 0;
  localparam int PRB_CMD_COMPLETE    = 1;
  localparam int PRB_HANDLEMATCH     = 2;
  localparam int PRB_DOCRC           = 3;
  localparam int PRB_RX_EN           = 4;
  localparam int PRB_TX_EN           = 5;

  function automatic int frame_len(input int probe_w, input int seq_w);
    return SYNC_W + seq_w + probe_w + 1;
  endfunction

endpackage

// File: rtl/debug_snapshot_sync2.sv
// Two-flop synchronizer of configurable width with asynchronous reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debug_snapshot.sv
// Snapshots synchronized probe flags and serializes them as one framed stream:
// sync header, sequence number, probe bits, even parity.
module debug_snapshot
  import debug_pkg::*;
#(
  parameter int                PROBE_W  = PROBE_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                SEQ_W    = SEQ_W_DEF
) (
  input  logic               debug_clk,
  input  logic               reset,
  input  logic [PROBE_W-1:0] probe_in,
  input  logic               debug_arm,
  output logic               debug_out,
  output logic               frame_active,
  output logic               frame_done,
  output logic [SEQ_W-1:0]   seq_out
);

  localparam int FRAME_LEN = frame_len(PROBE_W, SEQ_W);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  logic [PROBE_W-1:0]   probe_s2;
  logic                 arm_s2;
  logic [1:0]           state;
  logic [FRAME_LEN-1:0] sr;
  logic [FRAME_LEN-1:0] frame_word;
  logic [CNT_W-1:0]     bitcnt;
  logic [SEQ_W-1:0]     seq;

  sync2 #(.W(PROBE_W)) u_probe_sync (
    .clk   (debug_clk),
    .reset (reset),
    .d     (probe_in),
    .q     (probe_s2)
  );

  sync2 #(.W(1)) u_arm_sync (
    .clk   (debug_clk),
    .reset (reset),
    .d     (debug_arm),
    .q     (arm_s2)
  );

  function automatic logic even_parity(input logic [SEQ_W-1:0] s, input logic [PROBE_W-1:0] p);
    return ^{s, p};
  endfunction

  // Frame laid out in transmit order so bit 0 leaves first; header goes MSB first.
  always_comb begin
    frame_word = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      frame_word[i] = SYNC_PAT[SYNC_W-1-i];
    end
    frame_word[SYNC_W +: SEQ_W]           = seq;
    frame_word[SYNC_W+SEQ_W +: PROBE_W]   = probe_s2;
    frame_word[FRAME_LEN-1]               = even_parity(seq, probe_s2);
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sr           <= '0;
      bitcnt       <= '0;
      seq          <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm_s2) begin
            state <= ST_CAPTURE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          sr           <= frame_word;
          bitcnt       <= '0;
          frame_active <= 1'b1;
          state        <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // After FRAME_LEN shifts the register is all zero, so debug_out idles low.
          sr <= {1'b0, sr[FRAME_LEN-1:1]};
          if (bitcnt == LAST_BIT) begin
            frame_active <= 1'b0;
            frame_done   <= 1'b1;
            state        <= ST_GAP;
          end else begin
            bitcnt <= bitcnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          frame_done <= 1'b0;
          seq        <= seq + SEQ_W'(1);
          if (arm_s2) begin
            state <= ST_CAPTURE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state        <= ST_IDLE;
          sr           <= '0;
          bitcnt       <= '0;
          frame_active <= 1'b0;
          frame_done   <= 1'b0;
        end
      endcase
    end
  end

  assign debug_out = sr[0];
  assign seq_out   = seq;

endmodule

// File: tb/tb_debug_snapshot.sv
// Self-checking bench for debug_snapshot: randomized probe values checked
// against a frame model built directly from the framing rules.
module tb_debug_snapshot;

  localparam int PW = 16;
  localparam int SW = 4;
  localparam int FL = 25;

  logic          debug_clk = 1'b0;
  logic          reset;
  logic          debug_arm;
  logic [PW-1:0] probe_in;
  logic          debug_out;
  logic          frame_active;
  logic          frame_done;
  logic [SW-1:0] seq_out;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int exp_seq = 0;
  int drop_arm_at = -1;
  int probe_at = -1;
  logic [PW-1:0] next_probe = '0;

  debug_snapshot dut (
    .debug_clk    (debug_clk),
    .reset        (reset),
    .probe_in     (probe_in),
    .debug_arm    (debug_arm),
    .debug_out    (debug_out),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .seq_out      (seq_out)
  );

  always #5 debug_clk = ~debug_clk;

  always @(posedge debug_clk) cyc <= cyc + 1;

  // Expected frame, bit i = i-th transmitted bit.
  function automatic logic [FL-1:0] model_frame(input int seqn, input logic [PW-1:0] probe);
    logic [FL-1:0] f;
    logic [3:0]    sync;
    logic [SW-1:0] s;
    logic          par;
    int            n;
    sync = 4'b1010;
    s    = SW'(seqn % 16);
    f    = '0;
    n    = 0;
    par  = 1'b0;
    for (int i = 3; i >= 0; i--) begin f[n] = sync[i]; n++; end
    for (int i = 0; i < SW; i++) begin f[n] = s[i]; par = par ^ s[i]; n++; end
    for (int i = 0; i < PW; i++) begin f[n] = probe[i]; par = par ^ probe[i]; n++; end
    f[n] = par;
    return f;
  endfunction

  // Waits (bounded) for a frame and records its bits; samples 1 time unit after each edge.
  task automatic get_frame(output logic [FL-1:0] bits, output bit ok, output int start_cyc);
    bits = '0;
    ok = 1'b0;
    start_cyc = 0;
    for (int w = 0; w < 200 && frame_active !== 1'b1; w++) begin
      @(posedge debug_clk); #1;
    end
    if (frame_active !== 1'b1) return;
    ok = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) begin @(posedge debug_clk); #1; end
      bits[i] = debug_out;
      if (frame_active !== 1'b1) ok = 1'b0;
      if (i == drop_arm_at) debug_arm = 1'b0;
      if (i == probe_at) probe_in = next_probe;
    end
  endtask

  task automatic do_reset();
    @(negedge debug_clk);
    reset = 1'b1;
    repeat (2) @(posedge debug_clk);
    @(negedge debug_clk);
    reset = 1'b0;
    exp_seq = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    debug_arm = 1'b0;
    probe_in = '0;
    repeat (3) @(posedge debug_clk);
    #1;
    checks++; if (debug_out !== 1'b0) $display("FAIL reset_debug_out got %0b want 0", debug_out); else passes++;
    checks++; if (frame_active !== 1'b0) $display("FAIL reset_frame_active got %0b want 0", frame_active); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %0b want 0", frame_done); else passes++;
    checks++; if (seq_out !== 4'd0) $display("FAIL reset_seq_out got %0d want 0", seq_out); else passes++;
    @(negedge debug_clk);
    reset = 1'b0;
    exp_seq = 0;
  endtask

  task automatic test_single_frame();
    logic [FL-1:0] bits;
    logic [FL-1:0] lit;
    bit ok;
    int st;
    lit = {1'b0, 16'h00A5, 4'h0, 4'b0101};
    probe_in = 16'h00A5;
    repeat (3) @(negedge debug_clk);
    debug_arm = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge debug_clk); #1;
      checks++;
      if (frame_active !== ((k == 4) ? 1'b1 : 1'b0))
        $display("FAIL single_latency edge %0d frame_active got %0b", k, frame_active);
      else passes++;
      if (k == 3) debug_arm = 1'b0;
    end
    get_frame(bits, ok, st);
    checks++; if (!ok) $display("FAIL single_frame_seen got no complete frame want 25 bits"); else passes++;
    checks++; if (bits !== lit) $display("FAIL single_bits got %b want %b", bits, lit); else passes++;
    @(posedge debug_clk); #1;
    checks++; if (frame_done !== 1'b1 || debug_out !== 1'b0)
      $display("FAIL single_gap got done=%0b out=%0b want 1,0", frame_done, debug_out); else passes++;
    exp_seq++;
    @(posedge debug_clk); #1;
    checks++; if (frame_done !== 1'b0 || seq_out !== SW'(exp_seq % 16))
      $display("FAIL single_after got done=%0b seq=%0d want 0,%0d", frame_done, seq_out, exp_seq % 16); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [FL-1:0] bits;
    logic [PW-1:0] cur;
    bit ok;
    int st;
    int prev;
    do_reset();
    cur = PW'($urandom);
    probe_in = cur;
    prev = 0;
    repeat (3) @(negedge debug_clk);
    debug_arm = 1'b1;
    for (int f = 0; f < 17; f++) begin
      next_probe = PW'($urandom);
      probe_at = 10;
      if (f == 16) drop_arm_at = 10;
      get_frame(bits, ok, st);
      checks++; if (!ok) $display("FAIL b2b_seen frame %0d incomplete", f); else passes++;
      checks++; if (bits !== model_frame(exp_seq, cur))
        $display("FAIL b2b_bits frame %0d got %b want %b", f, bits, model_frame(exp_seq, cur)); else passes++;
      if (f > 0) begin
        checks++; if (st - prev != 27) $display("FAIL b2b_period frame %0d got %0d want 27", f, st - prev); else passes++;
      end
      prev = st;
      cur = next_probe;
      @(posedge debug_clk); #1;
      checks++; if (frame_done !== 1'b1) $display("FAIL b2b_done frame %0d got %0b want 1", f, frame_done); else passes++;
      exp_seq++;
    end
    probe_at = -1;
    drop_arm_at = -1;
    @(posedge debug_clk); #1;
    checks++; if (seq_out !== SW'(exp_seq % 16))
      $display("FAIL b2b_seq_wrap got %0d want %0d", seq_out, exp_seq % 16); else passes++;
  endtask

  task automatic test_arm_drop();
    logic [FL-1:0] bits;
    logic [PW-1:0] p;
    bit ok;
    int st;
    int starts;
    p = PW'($urandom);
    probe_in = p;
    repeat (3) @(negedge debug_clk);
    debug_arm = 1'b1;
    drop_arm_at = 10;
    get_frame(bits, ok, st);
    drop_arm_at = -1;
    checks++; if (!ok) $display("FAIL drop_seen frame incomplete"); else passes++;
    checks++; if (bits !== model_frame(exp_seq, p))
      $display("FAIL drop_bits got %b want %b", bits, model_frame(exp_seq, p)); else passes++;
    @(posedge debug_clk); #1;
    checks++; if (frame_done !== 1'b1) $display("FAIL drop_done got %0b want 1", frame_done); else passes++;
    exp_seq++;
    starts = 0;
    repeat (40) begin
      @(posedge debug_clk); #1;
      if (frame_active === 1'b1) starts++;
    end
    checks++; if (starts != 0) $display("FAIL drop_no_second got %0d active cycles want 0", starts); else passes++;
    checks++; if (seq_out !== SW'(exp_seq % 16))
      $display("FAIL drop_seq got %0d want %0d", seq_out, exp_seq % 16); else passes++;
  endtask

  task automatic test_probe_change();
    logic [FL-1:0] bits;
    bit ok;
    int st;
    do_reset();
    probe_in = 16'hFFFF;
    repeat (3) @(negedge debug_clk);
    debug_arm = 1'b1;
    next_probe = 16'h0000;
    probe_at = 5;
    get_frame(bits, ok, st);
    probe_at = -1;
    checks++; if (!ok) $display("FAIL pchg_seen first frame incomplete"); else passes++;
    checks++; if (bits[23:8] !== 16'hFFFF || bits[24] !== 1'b0)
      $display("FAIL pchg_first got data=%h par=%0b want ffff,0", bits[23:8], bits[24]); else passes++;
    checks++; if (bits !== model_frame(0, 16'hFFFF))
      $display("FAIL pchg_first_bits got %b want %b", bits, model_frame(0, 16'hFFFF)); else passes++;
    @(posedge debug_clk); #1;
    exp_seq++;
    drop_arm_at = 10;
    get_frame(bits, ok, st);
    drop_arm_at = -1;
    checks++; if (bits !== model_frame(exp_seq, 16'h0000) || !ok)
      $display("FAIL pchg_second got %b want %b", bits, model_frame(exp_seq, 16'h0000)); else passes++;
    @(posedge debug_clk); #1;
    exp_seq++;
    repeat (5) @(posedge debug_clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [FL-1:0] bits;
    logic [PW-1:0] p;
    bit ok;
    int st;
    p = PW'($urandom);
    probe_in = p;
    @(negedge debug_clk);
    debug_arm = 1'b1;
    for (int w = 0; w < 100 && frame_active !== 1'b1; w++) begin
      @(posedge debug_clk); #1;
    end
    checks++; if (frame_active !== 1'b1) $display("FAIL rmid_start got no frame"); else passes++;
    repeat (7) @(posedge debug_clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (debug_out !== 1'b0 || frame_active !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL rmid_abort got out=%0b act=%0b done=%0b want 0,0,0", debug_out, frame_active, frame_done); else passes++;
    checks++; if (seq_out !== 4'd0) $display("FAIL rmid_seq got %0d want 0", seq_out); else passes++;
    repeat (2) @(posedge debug_clk);
    @(negedge debug_clk);
    reset = 1'b0;
    exp_seq = 0;
    drop_arm_at = 10;
    get_frame(bits, ok, st);
    drop_arm_at = -1;
    checks++; if (!ok || bits !== model_frame(0, p))
      $display("FAIL rmid_next got %b want %b", bits, model_frame(0, p)); else passes++;
    @(posedge debug_clk); #1;
    checks++; if (frame_done !== 1'b1) $display("FAIL rmid_done got %0b want 1", frame_done); else passes++;
    exp_seq++;
    repeat (3) @(posedge debug_clk);
  endtask

  initial begin
    reset = 1'b1;
    debug_arm = 1'b0;
    probe_in = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_arm_drop();
    test_probe_change();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
